bram_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port bram between the instruction-fetch port (imem) and the load/store port (dmem).
- Each requester issues one-cycle request pulses. The arbiter captures each pulse into a per-port pending slot and drives the bram request, holding it stable until bram_ready.
- The read data and ready pulse are routed back to the owning requester only.
- Sits between the cpu-medium core memory ports and the bram.

---
 rtl/bram_arbiter.sv | 147 ++++++++++++++
 tb/tb_bram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - imem/dmem arbiter for a single-port bram; BRAM_ARB_RR_EN selects round-robin
module bram_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t      state_q, state_d;
    logic        pend_i_q, pend_i_d;
    logic [31:0] addr_i_q, addr_i_d;
    logic        pend_d_q, pend_d_d;
    logic [31:0] addr_d_q, addr_d_d;
    logic [31:0] wdata_d_q, wdata_d_d;
    logic [3:0]  wstrb_d_q, wstrb_d_d;
    logic        last_d_q, last_d_d;     // 1: dmem owned the most recent grant
    logic        bram_valid_q, bram_valid_d;
    logic        bram_instr_q, bram_instr_d;
    logic [31:0] bram_addr_q, bram_addr_d;
    logic [31:0] bram_wdata_q, bram_wdata_d;
    logic [3:0]  bram_wstrb_q, bram_wstrb_d;
    logic        done_i, done_d, pick_d;

    assign done_i = (state_q == GRANT_I) && bram_ready;
    assign done_d = (state_q == GRANT_D) && bram_ready;

    assign imem_ready = done_i;
    assign dmem_ready = done_d;
    assign imem_rdata = done_i ? bram_rdata : 32'h0;
    assign dmem_rdata = done_d ? bram_rdata : 32'h0;

    assign bram_valid = bram_valid_q;
    assign bram_instr = bram_instr_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_wstrb = bram_wstrb_q;

    // Pending slots: release on completion, then accept a pulse only into a free slot
    always_comb begin
        pend_i_d  = pend_i_q & ~done_i;
        addr_i_d  = addr_i_q;
        pend_d_d  = pend_d_q & ~done_d;
        addr_d_d  = addr_d_q;
        wdata_d_d = wdata_d_q;
        wstrb_d_d = wstrb_d_q;
        last_d_d  = last_d_q;
        if (done_d) begin
            last_d_d = 1'b1;
        end else if (done_i) begin
            last_d_d = 1'b0;
        end
        if (imem_valid && !pend_i_d) begin
            pend_i_d = 1'b1;
            addr_i_d = imem_addr;
        end
        if (dmem_valid && !pend_d_d) begin
            pend_d_d  = 1'b1;
            addr_d_d  = dmem_addr;
            wdata_d_d = dmem_wdata;
            wstrb_d_d = dmem_wstrb;
        end
    end

    // Winner selection among the slots as they will stand after this edge
    always_comb begin
`ifdef BRAM_ARB_RR_EN
        pick_d = pend_d_d && (!pend_i_d || !last_d_d);
`else
        pick_d = pend_d_d;
`endif
    end

    // Grant sequencing: arbitrate when idle or on completion, otherwise hold the request
    always_comb begin
        state_d      = state_q;
        bram_valid_d = bram_valid_q;
        bram_instr_d = bram_instr_q;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        bram_wstrb_d = bram_wstrb_q;
        if (state_q == IDLE || done_i || done_d) begin
            if (pend_i_d || pend_d_d) begin
                state_d      = pick_d ? GRANT_D : GRANT_I;
                bram_valid_d = 1'b1;
                bram_instr_d = !pick_d;
                bram_addr_d  = pick_d ? addr_d_d : addr_i_d;
                bram_wdata_d = pick_d ? wdata_d_d : 32'h0;
                bram_wstrb_d = pick_d ? wstrb_d_d : 4'h0;
            end else begin
                state_d      = IDLE;
                bram_valid_d = 1'b0;
                bram_instr_d = 1'b0;
            end
        end
    end

    // State, slots and registered bram request
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_i_q     <= 1'b0;
            addr_i_q     <= 32'h0;
            pend_d_q     <= 1'b0;
            addr_d_q     <= 32'h0;
            wdata_d_q    <= 32'h0;
            wstrb_d_q    <= 4'h0;
            last_d_q     <= 1'b1;
            bram_valid_q <= 1'b0;
            bram_instr_q <= 1'b0;
            bram_addr_q  <= 32'h0;
            bram_wdata_q <= 32'h0;
            bram_wstrb_q <= 4'h0;
        end else begin
            state_q      <= state_d;
            pend_i_q     <= pend_i_d;
            addr_i_q     <= addr_i_d;
            pend_d_q     <= pend_d_d;
            addr_d_q     <= addr_d_d;
            wdata_d_q    <= wdata_d_d;
            wstrb_d_q    <= wstrb_d_d;
            last_d_q     <= last_d_d;
            bram_valid_q <= bram_valid_d;
            bram_instr_q <= bram_instr_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_wstrb_q <= bram_wstrb_d;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter against a transaction-level model
module tb_bram_arbiter;

`ifdef BRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = 32'h0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic [3:0]  dmem_wstrb = 4'h0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata;
    logic        bram_ready;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    bram_arbiter dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .bram_valid(bram_valid), .bram_instr(bram_instr), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata), .bram_ready(bram_ready)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 32'h01010101;
            8'd1:    return 32'h02020202;
            8'd2:    return 32'h03030303;
            8'd4:    return 32'hDEADBEEF;
            8'd8:    return 32'hA0B0C0D0;
            default: return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // bram environment: ready after bram_cycle extra cycles of a held request
    logic [31:0] bram_mem [0:255];
    bit          bram_wr  [0:255];
    int          bram_cycle = 2;
    int          bram_cnt = 0;
    logic [7:0]  bidx;
    assign bidx       = bram_addr[9:2];
    assign bram_ready = (bram_valid === 1'b1) && (bram_cnt == bram_cycle);
    assign bram_rdata = bram_wr[bidx] ? bram_mem[bidx] : init_word(bidx);

    always @(posedge clock) begin
        if (bram_valid === 1'b1) begin
            if (bram_ready) begin
                bram_cnt <= 0;
                if (bram_wstrb != 4'h0) begin
                    bram_mem[bidx] <= merge(bram_rdata, bram_wdata, bram_wstrb);
                    bram_wr[bidx]  <= 1'b1;
                end
            end else begin
                bram_cnt <= bram_cnt + 1;
            end
        end else begin
            bram_cnt <= 0;
        end
    end

    // Transaction-level reference: pending requests per port, current owner, reference memory
    typedef struct {
        bit          pi;
        logic [31:0] ai;
        bit          pd;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [3:0]  sd;
        int          owner;   // 0 none, 1 imem, 2 dmem
        int          last;    // 1 imem, 2 dmem
    } model_t;

    model_t      m;
    logic [31:0] ref_mem [0:255];
    bit          ref_wr  [0:255];

    function automatic logic [31:0] ref_word(input logic [7:0] idx);
        return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
    endfunction

    function automatic model_t step(input model_t cur, input logic rst,
                                    input logic iv, input logic [31:0] ia,
                                    input logic dv, input logic [31:0] da, input logic [31:0] dw,
                                    input logic [3:0] ds, input logic rdy);
        model_t n = cur;
        bit fin_i = (cur.owner == 1) && rdy;
        bit fin_d = (cur.owner == 2) && rdy;
        if (fin_i) begin n.pi = 0; n.last = 1; end
        if (fin_d) begin n.pd = 0; n.last = 2; end
        if (iv && !n.pi) begin n.pi = 1; n.ai = ia; end
        if (dv && !n.pd) begin n.pd = 1; n.ad = da; n.wd = dw; n.sd = ds; end
        if (cur.owner == 0 || fin_i || fin_d) begin
            if (n.pi && n.pd) n.owner = RR_EN ? ((n.last == 2) ? 1 : 2) : 2;
            else if (n.pd)    n.owner = 2;
            else if (n.pi)    n.owner = 1;
            else              n.owner = 0;
        end
        if (rst) begin n.pi = 0; n.pd = 0; n.owner = 0; n.last = 2; end
        return n;
    endfunction

    // Per-cycle compare against the model, then advance the model with this cycle's inputs
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_bram_valid", 32'(bram_valid), 32'(m.owner != 0));
            chk("m_imem_ready", 32'(imem_ready), 32'((m.owner == 1) && bram_ready));
            chk("m_dmem_ready", 32'(dmem_ready), 32'((m.owner == 2) && bram_ready));
            chk("m_imem_rdata", imem_rdata, ((m.owner == 1) && bram_ready) ? ref_word(m.ai[9:2]) : 32'h0);
            chk("m_dmem_rdata", dmem_rdata, ((m.owner == 2) && bram_ready) ? ref_word(m.ad[9:2]) : 32'h0);
            if (m.owner != 0) begin
                chk("m_bram_instr", 32'(bram_instr), 32'(m.owner == 1));
                chk("m_bram_addr",  bram_addr,  (m.owner == 1) ? m.ai : m.ad);
                chk("m_bram_wdata", bram_wdata, (m.owner == 1) ? 32'h0 : m.wd);
                chk("m_bram_wstrb", 32'(bram_wstrb), (m.owner == 1) ? 32'h0 : 32'(m.sd));
            end
        end
        if (m.owner == 2 && bram_ready && m.sd != 4'h0) begin
            ref_mem[m.ad[9:2]] <= merge(ref_word(m.ad[9:2]), m.wd, m.sd);
            ref_wr[m.ad[9:2]]  <= 1'b1;
        end
        m <= step(m, reset, imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb, bram_ready);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_req(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] data, output int lat,
                           output bit instr_bad);
        tick();
        if (is_d) begin
            dmem_valid = 1; dmem_addr = addr; dmem_wdata = wdata; dmem_wstrb = wstrb;
        end else begin
            imem_valid = 1; imem_addr = addr;
        end
        lat = -1; instr_bad = 0; data = 32'h0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            imem_valid = 0; dmem_valid = 0;
            if (bram_valid && (bram_instr == is_d)) instr_bad = 1;
            if (is_d ? dmem_ready : imem_ready) begin
                lat = k;
                data = is_d ? dmem_rdata : imem_rdata;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        imem_valid = 0; dmem_valid = 0;
        while (bram_valid !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(bram_valid), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        int          lat, cd, ci, n, cnt;
        bit          ibad, gap;
        logic [5:0]  vbits, dbits, ibits;
        int          seq [0:9];

        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        chk_en = 1;

        chk("rst_bram_valid", 32'(bram_valid), 32'h0);
        chk("rst_bram_instr", 32'(bram_instr), 32'h0);
        chk("rst_bram_addr",  bram_addr, 32'h0);
        chk("rst_bram_wdata", bram_wdata, 32'h0);
        chk("rst_bram_wstrb", 32'(bram_wstrb), 32'h0);
        chk("rst_readies",    32'({imem_ready, dmem_ready}), 32'h0);

        // Single load, bram_cycle=2
        bram_cycle = 2;
        tick();
        dmem_valid = 1; dmem_addr = 32'h10; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        vbits = 0; dbits = 0; ibits = 0; data = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                tick();
                dmem_valid = 0;
            end
            vbits[k] = bram_valid;
            dbits[k] = dmem_ready;
            ibits[k] = imem_ready;
            if (dmem_ready) data = dmem_rdata;
        end
        chk("load_valid_cycles", 32'(vbits), 32'b001110);
        chk("load_ready_cycle",  32'(dbits), 32'b001000);
        chk("load_no_imem",      32'(ibits), 32'h0);
        chk("load_rdata",        data, 32'hDEADBEEF);

        // Store then fetch of the same word
        run_req(1, 32'h20, 32'h11223344, 4'b0101, data, lat, ibad);
        chk("store_latency", lat, 3);
        chk("store_instr",   32'(ibad), 32'h0);
        run_req(0, 32'h20, 32'h0, 4'h0, data, lat, ibad);
        chk("fetch_latency", lat, 3);
        chk("fetch_instr",   32'(ibad), 32'h0);
        chk("fetch_rdata",   data, 32'hA022C044);

        // Simultaneous pulses in idle
        tick();
        imem_valid = 1; imem_addr = 32'h0;
        dmem_valid = 1; dmem_addr = 32'h4; dmem_wstrb = 4'h0;
        cd = -1; ci = -1; gap = 0;
        for (int k = 1; k <= 40 && ci < 0; k++) begin
            tick();
            imem_valid = 0; dmem_valid = 0;
            if (!bram_valid) gap = 1;
            if (dmem_ready) begin cd = k; chk("simul_drdata", dmem_rdata, 32'h02020202); end
            if (imem_ready) begin ci = k; chk("simul_irdata", imem_rdata, 32'h01010101); end
        end
        chk("simul_d_cycle", cd, 3);
        chk("simul_i_cycle", ci, 6);
        chk("simul_no_gap",  32'(gap), 32'h0);

        // Starvation: each port re-requests in its own ready cycle
        tick();
        imem_valid = 1; imem_addr = 32'h0;
        dmem_valid = 1; dmem_addr = 32'h4; dmem_wstrb = 4'h0;
        n = 0;
        for (int k = 0; k < 200 && n < 10; k++) begin
            tick();
            imem_valid = imem_ready;
            dmem_valid = dmem_ready;
            if (dmem_ready) begin seq[n] = 2; n++; end
            else if (imem_ready) begin seq[n] = 1; n++; end
        end
        chk("starve_count", n, 10);
        for (int k = 0; k < 10; k++) begin
            if (k < n) chk($sformatf("starve_grant%0d", k), seq[k], (RR_EN && (k % 2 == 1)) ? 1 : 2);
        end
        tick();
        wait_idle("starve_drain");

        // Duplicate imem pulse while pending
        tick();
        imem_valid = 1; imem_addr = 32'h4;
        tick();
        imem_valid = 1; imem_addr = 32'h8;
        cnt = 0; data = 0;
        if (imem_ready) begin cnt++; data = imem_rdata; end
        for (int k = 0; k < 20; k++) begin
            tick();
            imem_valid = 0;
            if (imem_ready) begin cnt++; data = imem_rdata; end
        end
        chk("dup_ready_count", cnt, 1);
        chk("dup_rdata",       data, 32'h02020202);

        // Reset during GRANT_D before completion
        bram_cycle = 3;
        tick();
        dmem_valid = 1; dmem_addr = 32'h10; dmem_wstrb = 4'h0;
        tick();
        dmem_valid = 0;
        chk("rstmid_granted", 32'(bram_valid), 32'h1);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rstmid_valid_low", 32'(bram_valid), 32'h0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (dmem_ready) cnt++;
            tick();
        end
        chk("rstmid_no_ready", cnt, 0);
        run_req(1, 32'h10, 32'h0, 4'h0, data, lat, ibad);
        chk("rstmid_after_lat",   lat, 4);
        chk("rstmid_after_rdata", data, 32'hDEADBEEF);

        // Randomized traffic, checked every cycle by the model
        for (int blk = 0; blk < 6; blk++) begin
            wait_idle("rand_idle");
            bram_cycle = int'($urandom_range(0, 3));
            for (int k = 0; k < 500; k++) begin
                tick();
                reset      = ($urandom_range(0, 299) == 0);
                imem_valid = ($urandom_range(0, 3) == 0);
                imem_addr  = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
                dmem_valid = ($urandom_range(0, 2) == 0);
                dmem_addr  = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
                dmem_wdata = $urandom;
                dmem_wstrb = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            end
            tick();
            reset = 0;
        end
        wait_idle("final_idle");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
